bsearch_engine: RTL and testbench

Parametrised binary-search controller over an external sorted read-only memory with configurable read latency. Each search runs over a runtime length and supports three modes: exact match, lower bound (first element >= target) and upper bound (first element > target). It uses a start/busy/done handshake and reports the result index, a found flag and the probe count. It sits beside a sorted table RAM/ROM and is driven by a host FSM.

---
 rtl/bsearch_pkg.sv | 37 +++
 rtl/bsearch_engine_if.sv | 33 +++
 rtl/bsearch_cmp.sv | 27 ++
 rtl/bsearch_engine.sv | 205 ++++++++++++++++++++
 tb/tb_bsearch_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the binary-search engine.
// Holds the search modes, FSM states and sizing helpers.
package bsearch_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_LOWER = 2'b01,
        MODE_UPPER = 2'b10
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CHECK,
        ISSUE,
        WAIT,
        CMP,
        DONE
    } state_e;

    // Wait counter only has to hold MEM_LAT-2, so at least one bit.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

    // Encoding 2'b11 is reserved and searches as exact.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b01:   r = MODE_LOWER;
            2'b10:   r = MODE_UPPER;
            default: r = MODE_EXACT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bsearch_engine_if.sv
// Host request/response and table-memory read signals of the search engine.
// The engine uses the slave view; host plus memory use the master view.
interface bsearch_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);

    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] target;
    logic [ADDR_W:0]   len;

    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W:0]   result;
    logic [ADDR_W:0]   probes;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output start, mode, target, len, mem_rdata,
        input  busy, done, found, result, probes, mem_addr, mem_rd
    );

    modport slave (
        input  start, mode, target, len, mem_rdata,
        output busy, done, found, result, probes, mem_addr, mem_rd
    );

endinterface

// File: rtl/bsearch_cmp.sv
// Combinational ordering/equality of a table word against the search target.
// SIGNED selects two's-complement ordering; equality is always bitwise.
module bsearch_cmp #(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] target,
    output logic              lt,
    output logic              eq
);

    assign eq = (d == target);

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [DATA_W-1:0] d_s;
            logic signed [DATA_W-1:0] target_s;
            assign d_s      = d;
            assign target_s = target;
            assign lt       = (d_s < target_s);
        end else begin : g_unsigned
            assign lt = (d < target);
        end
    endgenerate

endmodule

// File: rtl/bsearch_engine.sv
// Binary-search controller over a sorted external table with MEM_LAT read latency.
// Supports exact, lower-bound and upper-bound searches on a half-open [lo, hi) range.
module bsearch_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int MEM_LAT = 1,
    parameter int SIGNED  = 0
) (
    input logic             clk,
    input logic             rst,
    bsearch_engine_if.slave bus
);

    localparam int AW1   = ADDR_W + 1;
    localparam int CNT_W = lat_cnt_w(MEM_LAT);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [AW1-1:0]   DEPTH_C   = AW1'(DEPTH);

    state_e            state;
    state_e            state_nxt;
    mode_e             mode_q;
    logic [DATA_W-1:0] target_q;
    logic [AW1-1:0]    len_q;
    logic [AW1-1:0]    len_clamped;
    logic [AW1-1:0]    lo;
    logic [AW1-1:0]    hi;
    logic [AW1-1:0]    mid;
    logic              eq_lo;
    logic              eq_hi;
    logic [CNT_W-1:0]  wait_cnt;
    logic              found_q;
    logic [AW1-1:0]    result_q;
    logic [AW1-1:0]    probes_q;
    logic              d_lt;
    logic              d_eq;
    logic              exact_hit;

    assign len_clamped = (bus.len > DEPTH_C) ? DEPTH_C : bus.len;

    // hi-lo never underflows because lo <= hi holds throughout a search.
    assign mid = lo + ((hi - lo) >> 1);

    bsearch_cmp #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .d      (bus.mem_rdata),
        .target (target_q),
        .lt     (d_lt),
        .eq     (d_eq)
    );

    assign exact_hit = (mode_q == MODE_EXACT) && d_eq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.busy     = (state != IDLE);
        bus.done     = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = (lo < hi) ? ISSUE : DONE;
            end
            ISSUE: begin
                bus.mem_rd   = 1'b1;
                // mid < len <= DEPTH, so dropping the top bit loses nothing.
                bus.mem_addr = mid[ADDR_W-1:0];
                state_nxt    = (MEM_LAT > 1) ? WAIT : CMP;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = exact_hit ? DONE : CHECK;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and host-visible results: cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            found_q  <= 1'b0;
            result_q <= '0;
            probes_q <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        probes_q <= '0;
                    end
                end
                CHECK: begin
                    if (!(lo < hi)) begin
                        result_q <= lo;
                        case (mode_q)
                            MODE_LOWER: found_q <= eq_hi;
                            MODE_UPPER: found_q <= eq_lo;
                            default:    found_q <= 1'b0;
                        endcase
                    end
                end
                ISSUE: begin
                    probes_q <= probes_q + 1'b1;
                    wait_cnt <= WAIT_INIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
                CMP: begin
                    if (exact_hit) begin
                        found_q  <= 1'b1;
                        result_q <= mid;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Search datapath: always initialised in IDLE/SETUP before use.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (bus.start) begin
                    mode_q   <= decode_mode(bus.mode);
                    target_q <= bus.target;
                    len_q    <= len_clamped;
                end
            end
            SETUP: begin
                lo    <= '0;
                hi    <= len_q;
                eq_lo <= 1'b0;
                eq_hi <= 1'b0;
            end
            CMP: begin
                case (mode_q)
                    MODE_LOWER: begin
                        if (d_lt) begin
                            lo <= mid + 1'b1;
                        end else begin
                            hi    <= mid;
                            eq_hi <= d_eq;
                        end
                    end
                    MODE_UPPER: begin
                        if (d_lt || d_eq) begin
                            lo    <= mid + 1'b1;
                            eq_lo <= d_eq;
                        end else begin
                            hi <= mid;
                        end
                    end
                    default: begin
                        if (!d_eq) begin
                            if (d_lt) begin
                                lo <= mid + 1'b1;
                            end else begin
                                hi <= mid;
                            end
                        end
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    assign bus.found  = found_q;
    assign bus.result = result_q;
    assign bus.probes = probes_q;

endmodule

// File: tb/tb_bsearch_engine.sv
// Bench for bsearch_engine: three instances (latency 1/3 unsigned, latency 2 signed)
// searched in lock-step and compared against a reference search model.
`timescale 1ns/1ps
module tb_bsearch_engine;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
    localparam int LAT2  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] target;
    logic [AW:0]   len;

    logic [DW-1:0] memu  [DEPTH];
    logic [DW-1:0] mems  [DEPTH];
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1 [LAT1];
    logic [DW-1:0] pipe2 [LAT2];

    bsearch_engine_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    bsearch_engine_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    bsearch_engine_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

    assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
    assign if0.mode = mode;    assign if1.mode = mode;    assign if2.mode = mode;
    assign if0.target = target; assign if1.target = target; assign if2.target = target;
    assign if0.len = len;      assign if1.len = len;      assign if2.len = len;
    assign if0.mem_rdata = pipe0;
    assign if1.mem_rdata = pipe1[LAT1-1];
    assign if2.mem_rdata = pipe2[LAT2-1];

    // Table memories: data valid MEM_LAT cycles after the read strobe.
    always @(posedge clk) begin
        pipe0    <= if0.mem_rd ? memu[if0.mem_addr] : 'x;
        pipe1[0] <= if1.mem_rd ? memu[if1.mem_addr] : 'x;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
        pipe2[0] <= if2.mem_rd ? mems[if2.mem_addr] : 'x;
        pipe2[1] <= pipe2[0];
    end

    bsearch_engine #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MEM_LAT(LAT0), .SIGNED(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    bsearch_engine #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MEM_LAT(LAT1), .SIGNED(0))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    bsearch_engine #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MEM_LAT(LAT2), .SIGNED(1))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [2:0]    busy_v, done_v, rd_v, fnd_v;
    logic [AW-1:0] addr_v [3];
    logic [AW:0]   res_v  [3];
    logic [AW:0]   prb_v  [3];

    assign busy_v = {if2.busy, if1.busy, if0.busy};
    assign done_v = {if2.done, if1.done, if0.done};
    assign rd_v   = {if2.mem_rd, if1.mem_rd, if0.mem_rd};
    assign fnd_v  = {if2.found, if1.found, if0.found};
    assign addr_v[0] = if0.mem_addr; assign addr_v[1] = if1.mem_addr; assign addr_v[2] = if2.mem_addr;
    assign res_v[0]  = if0.result;   assign res_v[1]  = if1.result;   assign res_v[2]  = if2.result;
    assign prb_v[0]  = if0.probes;   assign prb_v[1]  = if1.probes;   assign prb_v[2]  = if2.probes;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference results, index 0 = unsigned table, 1 = signed table.
    int e_res [2];
    int e_fnd [2];
    int e_prb [2];
    int e_hit [2];
    int e_addr [2][DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int val(input logic [DW-1:0] x, input int sg);
        return (sg != 0) ? int'($signed(x)) : int'(x);
    endfunction

    function automatic logic [DW-1:0] mem_at(input int s, input int i);
        return (s != 0) ? mems[i] : memu[i];
    endfunction

    task automatic model(input int s, input logic [1:0] m, input logic [DW-1:0] t, input logic [AW:0] l);
        int L, tv, nlt, nle, lo, hi, mid, p, d, hit, hidx;
        L   = (int'(l) > DEPTH) ? DEPTH : int'(l);
        tv  = val(t, s);
        nlt = 0;
        nle = 0;
        for (int i = 0; i < L; i++) begin
            d = val(mem_at(s, i), s);
            if (d < tv)  nlt++;
            if (d <= tv) nle++;
        end
        lo = 0; hi = L; p = 0; hit = 0; hidx = 0;
        while (lo < hi && hit == 0) begin
            mid = (lo + hi) / 2;
            e_addr[s][p] = mid;
            p++;
            d = val(mem_at(s, mid), s);
            if (m == 2'b01) begin
                if (d < tv) lo = mid + 1; else hi = mid;
            end else if (m == 2'b10) begin
                if (d <= tv) lo = mid + 1; else hi = mid;
            end else if (d == tv) begin
                hit = 1; hidx = mid;
            end else if (d < tv) begin
                lo = mid + 1;
            end else begin
                hi = mid;
            end
        end
        e_prb[s] = p;
        e_hit[s] = hit;
        if (m == 2'b01) begin
            e_res[s] = nlt;
            e_fnd[s] = 0;
            if (nlt < L) e_fnd[s] = (val(mem_at(s, nlt), s) == tv) ? 1 : 0;
        end else if (m == 2'b10) begin
            e_res[s] = nle;
            e_fnd[s] = 0;
            if (nle > 0) e_fnd[s] = (val(mem_at(s, nle - 1), s) == tv) ? 1 : 0;
        end else begin
            e_res[s] = (hit != 0) ? hidx : nlt;
            e_fnd[s] = hit;
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [DW-1:0] t, input logic [AW:0] l, input string tag);
        int dc [3];
        int rdn [3];
        int dn [3];
        int bbad [3];
        int lat [3];
        int last, s, ecyc;
        lat = '{LAT0, LAT1, LAT2};
        model(0, m, t, l);
        model(1, m, t, l);
        for (int k = 0; k < 3; k++) begin
            dc[k] = -1; rdn[k] = 0; dn[k] = 0; bbad[k] = 0;
        end
        @(negedge clk);
        start = 1'b1; mode = m; target = t; len = l;
        last = 400;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 4 && int'(l) > 0) begin
                start  = 1'b1;
                target = t ^ 8'h5A;
            end
            if (c == 5) start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                s = (k == 2) ? 1 : 0;
                if (rd_v[k]) begin
                    if (rdn[k] < e_prb[s])
                        chk($sformatf("%s_addr%0d_u%0d", tag, rdn[k], k), 32'(addr_v[k]), 32'(e_addr[s][rdn[k]]));
                    rdn[k]++;
                end
                if (done_v[k]) dn[k]++;
                if (dc[k] < 0) begin
                    if (!busy_v[k]) bbad[k]++;
                    if (done_v[k]) dc[k] = c;
                end
            end
            if (dc[0] >= 0 && dc[1] >= 0 && dc[2] >= 0 && last == 400) last = c + 2;
        end
        for (int k = 0; k < 3; k++) begin
            s = (k == 2) ? 1 : 0;
            ecyc = ((e_hit[s] != 0) ? 2 : 3) + e_prb[s] * (lat[k] + 2);
            chk($sformatf("%s_donecyc_u%0d", tag, k), 32'(dc[k]), 32'(ecyc));
            chk($sformatf("%s_result_u%0d", tag, k), 32'(res_v[k]), 32'(e_res[s]));
            chk($sformatf("%s_found_u%0d", tag, k), 32'(fnd_v[k]), 32'(e_fnd[s]));
            chk($sformatf("%s_probes_u%0d", tag, k), 32'(prb_v[k]), 32'(e_prb[s]));
            chk($sformatf("%s_rdcount_u%0d", tag, k), 32'(rdn[k]), 32'(e_prb[s]));
            chk($sformatf("%s_donepulses_u%0d", tag, k), 32'(dn[k]), 32'd1);
            chk($sformatf("%s_busygap_u%0d", tag, k), 32'(bbad[k]), 32'd0);
            chk($sformatf("%s_idle_after_u%0d", tag, k), 32'(busy_v[k]), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_busy_u%0d", tag, k), 32'(busy_v[k]), 32'd0);
            chk($sformatf("%s_done_u%0d", tag, k), 32'(done_v[k]), 32'd0);
            chk($sformatf("%s_rd_u%0d", tag, k), 32'(rd_v[k]), 32'd0);
            chk($sformatf("%s_addr_u%0d", tag, k), 32'(addr_v[k]), 32'd0);
            chk($sformatf("%s_found_u%0d", tag, k), 32'(fnd_v[k]), 32'd0);
            chk($sformatf("%s_result_u%0d", tag, k), 32'(res_v[k]), 32'd0);
            chk($sformatf("%s_probes_u%0d", tag, k), 32'(prb_v[k]), 32'd0);
        end
    endtask

    initial begin
        logic [1:0]    rm;
        logic [DW-1:0] rt;
        logic [AW:0]   rl;

        rst = 1'b0; start = 1'b0; mode = 2'b00; target = '0; len = '0;
        for (int i = 0; i < DEPTH; i++) begin
            memu[i] = (i == 0) ? 8'd1 : (i < 4) ? 8'd3 : 8'(2 * i - 3);
            mems[i] = (i == 0) ? 8'(-8) : (i == 1) ? 8'(-5) : (i == 2) ? 8'(-1) : (i == 3) ? 8'd0 : 8'(2 * (i - 3));
        end
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        run(2'b01, 8'd3, 5'd16, "lower3");
        chk("spec_lower3_result", 32'(res_v[0]), 32'd1);
        chk("spec_lower3_found", 32'(fnd_v[0]), 32'd1);
        chk("spec_lower3_probes", 32'(prb_v[0]), 32'd5);

        run(2'b10, 8'd3, 5'd16, "upper3");
        chk("spec_upper3_result", 32'(res_v[0]), 32'd4);
        chk("spec_upper3_found", 32'(fnd_v[0]), 32'd1);

        run(2'b00, 8'd4, 5'd16, "exact4");
        chk("spec_exact4_result", 32'(res_v[0]), 32'd4);
        chk("spec_exact4_found", 32'(fnd_v[0]), 32'd0);
        chk("spec_exact4_probes", 32'(prb_v[0]), 32'd4);

        run(2'b01, 8'd30, 5'd16, "lower30");
        chk("spec_lower30_result", 32'(res_v[0]), 32'd16);

        run(2'b00, 8'd9, 5'd0, "len0");
        run(2'b11, 8'd27, 5'd16, "mode3");

        run(2'b00, 8'd27, 5'd16, "exact27");
        chk("spec_exact27_result_lat3", 32'(res_v[1]), 32'd15);
        chk("spec_exact27_found_lat3", 32'(fnd_v[1]), 32'd1);

        run(2'b01, 8'hFF, 5'd16, "lowerm1");
        chk("spec_signed_lowerm1_result", 32'(res_v[2]), 32'd2);
        chk("spec_signed_lowerm1_found", 32'(fnd_v[2]), 32'd1);

        run(2'b10, 8'd100, 5'd31, "clamp");
        run(2'b01, 8'd0, 5'd1, "len1");

        // Abort a search during the second probe's wait on the latency-3 instance.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; target = 8'd27; len = 5'd16;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 10) begin
                chk_zero("midreset");
                rst = 1'b1;
            end
            if (c > 10) begin
                chk($sformatf("postreset_rd_c%0d", c), 32'(rd_v), 32'd0);
                chk($sformatf("postreset_busy_c%0d", c), 32'(busy_v), 32'd0);
            end
            if (c == 9) rst = 1'b0;
        end
        run(2'b00, 8'd27, 5'd16, "after_reset");

        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) begin
                memu[0] = 8'($urandom_range(0, 40));
                mems[0] = 8'(int'($urandom_range(0, 20)) - 30);
                for (int i = 1; i < DEPTH; i++) begin
                    memu[i] = memu[i-1] + 8'($urandom_range(0, 3));
                    mems[i] = mems[i-1] + 8'($urandom_range(0, 3));
                end
            end
            rm = 2'($urandom_range(0, 3));
            rl = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) rt = memu[$urandom_range(0, DEPTH - 1)];
            else                           rt = 8'($urandom);
            run(rm, rt, rl, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
